ysyx_22040759_idu_pipe: RTL

YSYX_22040759_IDU_PIPE -- requirements
Module: ysyx_22040759_idu_pipe

---
 rtl/ysyx_22040759_idu_pipe.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040759_idu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040759_idu_pipe
// Description : Single-entry decode stage. Decodes an RV subset (addi, auipc,
//               lui, jal, jalr, beq, bne, load, store, add, sub, ebreak) into
//               a registered control bundle with valid/ready handshakes on
//               both sides, a flush input and a RUN/HALT state entered on
//               ebreak and left on resume.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040759_idu_pipe #(
    parameter int XLEN     = 64,
    parameter int FLUSH_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            resume,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      imm_sel,
    output logic [2:0]      alu_sel,
    output logic [1:0]      alu_a_sel,
    output logic [1:0]      alu_b_sel,
    output logic [1:0]      pc_sel,
    output logic [1:0]      wreg_sel,
    output logic            reg_wen,
    output logic            mem_wen,
    output logic            mem_ren,
    output logic            illegal,
    output logic            ebreak
);

    // Field encodings of the bundle
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_U    = 3'd2;
    localparam logic [2:0] IMM_J    = 3'd3;
    localparam logic [2:0] IMM_S    = 3'd4;
    localparam logic [2:0] IMM_B    = 3'd5;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_EQ   = 3'd2;
    localparam logic [2:0] ALU_NE   = 3'd3;

    localparam logic [1:0] A_REG    = 2'd0;
    localparam logic [1:0] A_PC     = 2'd1;
    localparam logic [1:0] A_ZERO   = 2'd2;
    localparam logic [1:0] B_REG    = 2'd0;
    localparam logic [1:0] B_IMM    = 2'd1;

    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_BR    = 2'd2;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_PC4   = 2'd1;
    localparam logic [1:0] WB_MEM   = 2'd2;

    // Opcodes
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Native-width load/store: ld/sd on RV64, lw/sw on RV32
    localparam logic [2:0] LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      imm_sel;
        logic [2:0]      alu_sel;
        logic [1:0]      alu_a_sel;
        logic [1:0]      alu_b_sel;
        logic [1:0]      pc_sel;
        logic [1:0]      wreg_sel;
        logic            reg_wen;
        logic            mem_wen;
        logic            mem_ren;
        logic            illegal;
        logic            ebreak;
    } bundle_t;

    state_t  state_q, state_d;
    logic    out_valid_q, out_valid_d;
    bundle_t bundle_q, bundle_d;
    bundle_t dec;

    logic    flush_w;
    logic    accept_w;

    logic [6:0] opcode_w;
    logic [2:0] funct3_w;
    logic [6:0] funct7_w;

    logic [XLEN-1:0] imm_i_w;
    logic [XLEN-1:0] imm_u_w;
    logic [XLEN-1:0] imm_j_w;
    logic [XLEN-1:0] imm_s_w;
    logic [XLEN-1:0] imm_b_w;

    // With flush support compiled out the stage never discards work
    if (FLUSH_EN != 0) begin : g_flush_en
        assign flush_w = flush;
    end else begin : g_flush_off
        assign flush_w = 1'b0;
    end

    assign opcode_w = inst[6:0];
    assign funct3_w = inst[14:12];
    assign funct7_w = inst[31:25];

    // All immediates are sign-extended from inst[31] straight to XLEN
    assign imm_i_w = {{(XLEN-11){inst[31]}}, inst[30:20]};
    assign imm_u_w = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
    assign imm_j_w = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_s_w = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
    assign imm_b_w = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept_w = in_valid && in_ready && !flush_w;

    // Decode the incoming word; anything not recognised stays illegal with all controls zero
    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.rd      = inst[11:7];
        dec.illegal = 1'b1;
        if (inst == INST_EBREAK) begin
            dec.illegal = 1'b0;
            dec.ebreak  = 1'b1;
            dec.rd      = 5'd0;
        end else begin
            case (opcode_w)
                OP_IMM: if (funct3_w == 3'b000) begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_I;
                    dec.alu_b_sel = B_IMM; dec.reg_wen = 1'b1;
                end
                OP_AUIPC: begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_U;
                    dec.alu_a_sel = A_PC; dec.alu_b_sel = B_IMM; dec.reg_wen = 1'b1;
                end
                OP_LUI: begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_U;
                    dec.alu_a_sel = A_ZERO; dec.alu_b_sel = B_IMM; dec.reg_wen = 1'b1;
                end
                OP_JAL: begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_J;
                    dec.alu_a_sel = A_PC; dec.alu_b_sel = B_IMM;
                    dec.pc_sel = PC_ALU; dec.wreg_sel = WB_PC4; dec.reg_wen = 1'b1;
                end
                OP_JALR: if (funct3_w == 3'b000) begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_I;
                    dec.alu_a_sel = A_REG; dec.alu_b_sel = B_IMM;
                    dec.pc_sel = PC_ALU; dec.wreg_sel = WB_PC4; dec.reg_wen = 1'b1;
                end
                OP_BR: if (funct3_w == 3'b000 || funct3_w == 3'b001) begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_B;
                    dec.alu_sel = (funct3_w == 3'b000) ? ALU_EQ : ALU_NE;
                    dec.alu_b_sel = B_REG; dec.pc_sel = PC_BR; dec.rd = 5'd0;
                end
                OP_LOAD: if (funct3_w == LS_F3) begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_I;
                    dec.alu_b_sel = B_IMM; dec.mem_ren = 1'b1;
                    dec.wreg_sel = WB_MEM; dec.reg_wen = 1'b1;
                end
                OP_STORE: if (funct3_w == LS_F3) begin
                    dec.illegal = 1'b0; dec.imm_sel = IMM_S;
                    dec.alu_b_sel = B_IMM; dec.mem_wen = 1'b1; dec.rd = 5'd0;
                end
                OP_REG: if (funct3_w == 3'b000 &&
                            (funct7_w == 7'b0000000 || funct7_w == 7'b0100000)) begin
                    dec.illegal = 1'b0;
                    dec.alu_sel = (funct7_w == 7'b0100000) ? ALU_SUB : ALU_ADD;
                    dec.alu_b_sel = B_REG; dec.reg_wen = 1'b1;
                end
                default: ;
            endcase
        end
        case (dec.imm_sel)
            IMM_I:   dec.imm = imm_i_w;
            IMM_U:   dec.imm = imm_u_w;
            IMM_J:   dec.imm = imm_j_w;
            IMM_S:   dec.imm = imm_s_w;
            IMM_B:   dec.imm = imm_b_w;
            default: dec.imm = '0;
        endcase
    end

    // Next state: flush beats a transfer, a transfer beats a plain drain
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush_w) begin
            out_valid_d = 1'b0;
        end else if (accept_w) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_RUN:  if (accept_w && dec.ebreak) state_d = ST_HALT;
            ST_HALT: if (resume)                 state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // State, valid and bundle registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = bundle_q.pc;
    assign out_imm   = bundle_q.imm;
    assign out_rs1   = bundle_q.rs1;
    assign out_rs2   = bundle_q.rs2;
    assign out_rd    = bundle_q.rd;
    assign imm_sel   = bundle_q.imm_sel;
    assign alu_sel   = bundle_q.alu_sel;
    assign alu_a_sel = bundle_q.alu_a_sel;
    assign alu_b_sel = bundle_q.alu_b_sel;
    assign pc_sel    = bundle_q.pc_sel;
    assign wreg_sel  = bundle_q.wreg_sel;
    assign reg_wen   = bundle_q.reg_wen;
    assign mem_wen   = bundle_q.mem_wen;
    assign mem_ren   = bundle_q.mem_ren;
    assign illegal   = bundle_q.illegal;
    assign ebreak    = bundle_q.ebreak;

endmodule
`default_nettype wire
